// File: rtl/piso_register_pkg.sv
// ----------------------------------------------------------------------------
// piso_register_pkg
// Shared definitions for the parallel-in / serial-out shift register:
// the serialisation order encoding and the legal range of the data width.
// ----------------------------------------------------------------------------
package piso_register_pkg;

    // Which end of the register is presented on the serial output.
    typedef enum logic {
        LSB_FIRST_ORDER = 1'b0,
        MSB_FIRST_ORDER = 1'b1
    } shift_order_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage : piso_register_pkg

// File: rtl/piso_register.sv
// ----------------------------------------------------------------------------
// piso_register
// Parallel-in / serial-out shift register. A word is captured with load=1 and
// its first bit is visible on q right after that edge; each edge with load=0
// shifts one position, filling the vacated end with FILL_BIT. There is no bit
// counter or busy flag: after WIDTH shifts q simply holds FILL_BIT, and
// framing is left to the user of the block.
//
// Parameters
//   WIDTH     : parallel data width (2..64)
//   MSB_FIRST : 1 = bit WIDTH-1 leaves first (shift left),
//               0 = bit 0 leaves first (shift right)
//   FILL_BIT  : value shifted into the vacated end (0 or 1)
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset, overrides load
//   load  : 1 = capture d, 0 = shift one position
//   d     : parallel data word
//   q     : serial output bit, taken straight from the register
// ----------------------------------------------------------------------------
module piso_register
    import piso_register_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int FILL_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             q
);

    // Elaboration-time parameter legality.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("piso_register: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_order
        $error("piso_register: MSB_FIRST=%0d must be 0 or 1", MSB_FIRST);
    end
    if (FILL_BIT != 0 && FILL_BIT != 1) begin : g_bad_fill
        $error("piso_register: FILL_BIT=%0d must be 0 or 1", FILL_BIT);
    end

    localparam shift_order_e ORDER = (MSB_FIRST == 1) ? MSB_FIRST_ORDER : LSB_FIRST_ORDER;
    localparam logic         FILL  = (FILL_BIT == 1);

    logic [WIDTH-1:0] sreg;

    // Reset wins over load; load wins over shift, discarding any unsent bits.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of sreg, which is what makes this a shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= d;
        end else if (ORDER == MSB_FIRST_ORDER) begin
            sreg <= {sreg[WIDTH-2:0], FILL};
        end else begin
            sreg <= {FILL, sreg[WIDTH-1:1]};
        end
    end

    // q is a plain wire from the outgoing end, so it only moves after an edge.
    assign q = (ORDER == MSB_FIRST_ORDER) ? sreg[WIDTH-1] : sreg[0];

endmodule : piso_register

// File: tb/tb_piso_register.sv
// ----------------------------------------------------------------------------
// tb_piso_register
// Directed bench for piso_register. Three instances share clk/reset/load/d:
//   dut_msb  : WIDTH=4, MSB_FIRST=1, FILL_BIT=0
//   dut_lsb  : WIDTH=4, MSB_FIRST=0, FILL_BIT=0
//   dut_fill : WIDTH=4, MSB_FIRST=1, FILL_BIT=1
// Expected serial bits are hand-computed and packed as {msb, lsb, fill}.
// Inputs change 1 time unit after a rising edge; outputs are sampled then too.
// ----------------------------------------------------------------------------
module tb_piso_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] d;
    logic       q_msb;
    logic       q_lsb;
    logic       q_fill;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piso_register #(.WIDTH(4), .MSB_FIRST(1), .FILL_BIT(0)) dut_msb (
        .clk(clk), .reset(reset), .load(load), .d(d), .q(q_msb)
    );
    piso_register #(.WIDTH(4), .MSB_FIRST(0), .FILL_BIT(0)) dut_lsb (
        .clk(clk), .reset(reset), .load(load), .d(d), .q(q_lsb)
    );
    piso_register #(.WIDTH(4), .MSB_FIRST(1), .FILL_BIT(1)) dut_fill (
        .clk(clk), .reset(reset), .load(load), .d(d), .q(q_fill)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held for two edges with load=1, d=1111: every q must read 0.
    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b1;
        d     = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({q_msb, q_lsb, q_fill} !== 3'b000) begin
                bad++;
                $display("FAIL reset edge %0d: got %b expected 000", i, {q_msb, q_lsb, q_fill});
            end
        end
    endtask

    // Load 1011 then shift five times.
    task automatic test_load_shift();
        logic [2:0] exp [6] = '{3'b111, 3'b010, 3'b101, 3'b111, 3'b001, 3'b001};
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load = (i == 0);
            d    = 4'b1011;
            tick();
            total++;
            if ({q_msb, q_lsb, q_fill} !== exp[i]) begin
                bad++;
                $display("FAIL load_shift step %0d: got %b expected %b", i, {q_msb, q_lsb, q_fill}, exp[i]);
            end
        end
    endtask

    // Load 1011, shift 2, reload 0100, shift 3.
    task automatic test_reload();
        logic [2:0] exp   [7] = '{3'b111, 3'b010, 3'b101, 3'b000, 3'b101, 3'b010, 3'b000};
        logic       ld    [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] dv    [7] = '{4'b1011, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            load = ld[i];
            d    = dv[i];
            tick();
            total++;
            if ({q_msb, q_lsb, q_fill} !== exp[i]) begin
                bad++;
                $display("FAIL reload step %0d: got %b expected %b", i, {q_msb, q_lsb, q_fill}, exp[i]);
            end
        end
    endtask

    // Load 1111, shift 1, reset+load together, shift 2, then load 1011 to resume.
    task automatic test_reset_mid_shift();
        logic [2:0] exp [6] = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111};
        logic       rs  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ld  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] dv  [6] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1011};
        for (int i = 0; i < 6; i++) begin
            reset = rs[i];
            load  = ld[i];
            d     = dv[i];
            tick();
            total++;
            if ({q_msb, q_lsb, q_fill} !== exp[i]) begin
                bad++;
                $display("FAIL reset_mid_shift step %0d: got %b expected %b", i, {q_msb, q_lsb, q_fill}, exp[i]);
            end
        end
        reset = 1'b0;
    endtask

    // Load 0000 then shift six times: q settles on FILL_BIT after WIDTH shifts.
    task automatic test_fill_steady();
        logic [2:0] exp [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001};
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            load = (i == 0);
            d    = 4'b0000;
            tick();
            total++;
            if ({q_msb, q_lsb, q_fill} !== exp[i]) begin
                bad++;
                $display("FAIL fill_steady step %0d: got %b expected %b", i, {q_msb, q_lsb, q_fill}, exp[i]);
            end
        end
    endtask

    // load held high while d toggles 0000/1111 every 15 time units (1.5
    // periods, never on an edge): q follows d as sampled at each edge.
    task automatic test_held_load();
        reset = 1'b0;
        load  = 1'b1;
        d     = 4'b0000;
        fork
            begin
                for (int t = 0; t < 7; t++) begin
                    #15 d = ~d;
                end
            end
            begin
                logic [3:0] d_at_edge;
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk);
                    d_at_edge = d;
                    #1;
                    total++;
                    if ({q_msb, q_lsb, q_fill} !== {d_at_edge[3], d_at_edge[0], d_at_edge[3]}) begin
                        bad++;
                        $display("FAIL held_load edge %0d: got %b expected %b", i,
                                 {q_msb, q_lsb, q_fill}, {d_at_edge[3], d_at_edge[0], d_at_edge[3]});
                    end
                end
            end
        join
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        load  = 1'b0;
        d     = 4'b0000;
        @(negedge clk);
        test_reset();
        test_load_shift();
        test_reload();
        test_reset_mid_shift();
        test_fill_steady();
        test_held_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_piso_register

// File: doc/piso_register.md
PISO_REGISTER -- requirements
Module: piso_register

Interface
REQ-001 Parameter WIDTH, default 4: parallel data width; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 means bit WIDTH-1 is shifted out first; 0 means bit 0 is shifted out first.
REQ-003 Parameter FILL_BIT, default 1'b0: value shifted into the vacated end of the register.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port load, input, 1 bit: 1 means capture d on this edge; 0 means shift one position on this edge.
REQ-007 Port d, input, WIDTH bits: parallel data word.
REQ-008 Port q, output, 1 bit: serial output bit.

Function
REQ-009 The block SHALL hold one WIDTH-bit internal shift register, sreg.
REQ-010 q SHALL be driven directly from sreg with no added logic: sreg[WIDTH-1] when MSB_FIRST=1, sreg[0] when MSB_FIRST=0.
- q therefore changes only after a rising clk edge.
REQ-011 On a rising edge with reset=0 and load=1, sreg SHALL take the value d.
- The first serial bit appears on q immediately after that edge (latency 0 cycles from load).
REQ-012 On a rising edge with reset=0 and load=0, sreg SHALL shift by one position.
- MSB_FIRST=1: shift left; FILL_BIT enters bit 0.
- MSB_FIRST=0: shift right; FILL_BIT enters bit WIDTH-1.
REQ-013 Shifting SHALL continue without limit while load=0.
- After WIDTH shifts, q SHALL output FILL_BIT steadily.
- There is no wrap-around or recirculation.
REQ-014 If load is asserted in the middle of a shift sequence, the new d SHALL replace sreg on that edge; the unsent bits are discarded.
REQ-015 If load is held high for several cycles, sreg SHALL reload d on every edge, so q follows the selected bit of d with a one-edge delay.
REQ-016 There is no handshake, busy flag or bit counter; framing is the responsibility of the user of the block.

Reset
REQ-017 On a rising edge with reset=1, sreg SHALL become all zeros and q SHALL become 0, whatever the value of load or d.
REQ-018 Reset SHALL take priority over load when both are asserted on the same edge.
REQ-019 Reset applied in the middle of a shift SHALL abort the shift.
- Operation resumes on the first edge with reset=0: load or shift according to load.
REQ-020 Before the first reset edge, the state of sreg is unspecified.
- A simulation-only initial value of zero is allowed.

Structure
REQ-021 No shared package is required; WIDTH, MSB_FIRST and FILL_BIT SHALL be module parameters.
REQ-022 The block SHALL be a single module with one clocked process and no sub-modules.
REQ-023 The module SHALL include parameter-legality checks that fail elaboration for WIDTH<2 and for MSB_FIRST or FILL_BIT outside {0,1}.

Verification
REQ-024 Reset check: reset=1 for two edges with load=1 and d=4'b1111 -> q=0 after each edge.
REQ-025 Load then shift, MSB-first: reset=0, load=1, d=4'b1011 for one edge, then load=0 -> q sequence after successive edges is 1,0,1,1,0,0.
REQ-026 LSB-first: MSB_FIRST=0, load d=4'b1011, then shift -> q sequence is 1,1,0,1,0.
REQ-027 Reload mid-shift: load 4'b1011, shift 2 edges, then load 4'b0100, then shift -> q sequence is 1,0,1,0,1,0,0.
REQ-028 Reset mid-shift: load 4'b1111, shift 1 edge, assert reset and load together for one edge -> q=0; then load=0 -> q stays 0.
REQ-029 Held load: load=1 while d toggles between 4'b0000 and 4'b1111 every 1.5 clock periods -> after each edge, q equals d[3] as sampled at that edge.
